// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the two-master bus arbiter.
// Also holds the round-robin pick used at arbitration time.
package bus_arbiter_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef logic master_idx_t;

    // On contention, the master that did not own the bus last time wins.
    function automatic master_idx_t rr_pick(input logic req0, input logic req1,
                                            input master_idx_t last_owner);
        if (req0 && req1) begin
            return ~last_owner;
        end else if (req0) begin
            return 1'b0;
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin burst arbiter in front of a single slave port.
// A grant is held, unpreempted, until the last beat of the captured burst.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_wr,
    input  logic              m0_rd,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [LEN_W-1:0]  m0_length,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_wr,
    input  logic              m1_rd,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [LEN_W-1:0]  m1_length,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              s_wr,
    output logic              s_rd,
    output logic [ADDR_W-1:0] s_address,
    output logic [LEN_W-1:0]  s_length,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,

    output logic              busy
);

    state_e             state_q,      state_d;
    master_idx_t        owner_q,      owner_d;
    master_idx_t        last_owner_q, last_owner_d;
    logic [LEN_W-1:0]   cnt_q,        cnt_d;
    logic [ADDR_W-1:0]  addr_q,       addr_d;
    logic [LEN_W-1:0]   len_q,        len_d;
    logic               dir_wr_q,     dir_wr_d;

    logic        req0;
    logic        req1;
    master_idx_t pick;

    assign req0 = m0_wr | m0_rd;
    assign req1 = m1_wr | m1_rd;
    assign pick = rr_pick(req0, req1, last_owner_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            dir_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            dir_wr_q     <= dir_wr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        len_d        = len_q;
        dir_wr_d     = dir_wr_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = BUSY;
                    owner_d = pick;
                    // Write wins when a master raises both wr and rd.
                    if (pick == 1'b0) begin
                        addr_d   = m0_address;
                        len_d    = m0_length;
                        cnt_d    = m0_length;
                        dir_wr_d = m0_wr;
                    end else begin
                        addr_d   = m1_address;
                        len_d    = m1_length;
                        cnt_d    = m1_length;
                        dir_wr_d = m1_wr;
                    end
                end
            end
            BUSY: begin
                if (s_ready) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Everything below is gated by BUSY so an async reset clears outputs at once.
    assign busy      = (state_q == BUSY);
    assign m0_gnt    = busy && (owner_q == 1'b0);
    assign m1_gnt    = busy && (owner_q == 1'b1);
    assign m0_ready  = m0_gnt && s_ready;
    assign m1_ready  = m1_gnt && s_ready;
    assign m0_rdata  = m0_gnt ? s_rdata : '0;
    assign m1_rdata  = m1_gnt ? s_rdata : '0;
    assign s_wr      = busy && dir_wr_q;
    assign s_rd      = busy && !dir_wr_q;
    assign s_address = busy ? addr_q : '0;
    assign s_length  = busy ? len_q : '0;
    assign s_wdata   = m0_gnt ? m0_wdata : (m1_gnt ? m1_wdata : '0);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: single bursts, contention, address wrap,
// write priority and asynchronous reset in the middle of a burst.
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_wr, m0_rd, m1_wr, m1_rd;
    logic [3:0]  m0_address, m1_address, m0_length, m1_length;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_wr, s_rd, s_ready, busy;
    logic [3:0]  s_address, s_length;
    logic [31:0] s_wdata, s_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    bus_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_address(m0_address), .m0_length(m0_length),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_address(m1_address), .m1_length(m1_length),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_wr(s_wr), .s_rd(s_rd), .s_address(s_address), .s_length(s_length),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_gnt0"},  32'(m0_gnt), 0);
        check({tag, "_gnt1"},  32'(m1_gnt), 0);
        check({tag, "_swr"},   32'(s_wr), 0);
        check({tag, "_srd"},   32'(s_rd), 0);
        check({tag, "_saddr"}, 32'(s_address), 0);
        check({tag, "_slen"},  32'(s_length), 0);
        check({tag, "_swdat"}, s_wdata, 0);
        check({tag, "_rdy0"},  32'(m0_ready), 0);
        check({tag, "_rdy1"},  32'(m1_ready), 0);
        check({tag, "_rdat0"}, m0_rdata, 0);
        check({tag, "_rdat1"}, m1_rdata, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        m0_wr = 0; m0_rd = 0; m1_wr = 0; m1_rd = 0;
        m0_address = 0; m1_address = 0; m0_length = 0; m1_length = 0;
        m0_wdata = 0; m1_wdata = 0; s_ready = 0; s_rdata = 32'hDEAD_BEEF;

        #3;
        check_all_zero("rst");

        // Single write burst, slave stalls three cycles.
        @(negedge clock);
        reset = 1'b1;
        m0_wr = 1; m0_address = 4'h6; m0_length = 4'd1; m0_wdata = 32'hA;
        #1 check("t1_pre_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check("t1_gnt0", 32'(m0_gnt), 1);
            check("t1_busy", 32'(busy), 1);
            check("t1_swr", 32'(s_wr), 1);
            check("t1_saddr_stall", 32'(s_address), 32'h6);
            check("t1_slen", 32'(s_length), 1);
            check("t1_swdata", s_wdata, 32'hA);
            check("t1_rdy0_stall", 32'(m0_ready), 0);
        end
        @(negedge clock); s_ready = 1; #1;
        check("t1_rdy0_b0", 32'(m0_ready), 1);
        check("t1_saddr_b0", 32'(s_address), 32'h6);
        @(negedge clock); m0_wr = 0; #1;
        check("t1_rdy0_b1", 32'(m0_ready), 1);
        check("t1_saddr_b1", 32'(s_address), 32'h7);
        @(negedge clock); #1;
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_idle_gnt0", 32'(m0_gnt), 0);
        check("t1_idle_swr", 32'(s_wr), 0);
        check("t1_idle_rdy0", 32'(m0_ready), 0);
        $display("txn1 m0 write addr=0x6 len=1 done");

        // Contention from reset: owners must go 0, 1, 0 with an idle gap each time.
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        m0_wr = 1; m1_wr = 1; m0_length = 0; m1_length = 0;
        m0_address = 4'h1; m1_address = 4'h2; m0_wdata = 32'h100; m1_wdata = 32'h200;
        for (int k = 0; k < 3; k++) begin
            logic exp_owner;
            exp_owner = (k == 1);
            @(negedge clock);
            if (k == 2) begin m0_wr = 0; m1_wr = 0; end
            #1;
            check("t2_busy", 32'(busy), 1);
            check("t2_gnt0", 32'(m0_gnt), 32'(!exp_owner));
            check("t2_gnt1", 32'(m1_gnt), 32'(exp_owner));
            check("t2_rdy1", 32'(m1_ready), 32'(exp_owner));
            check("t2_saddr", 32'(s_address), exp_owner ? 32'h2 : 32'h1);
            check("t2_swdata", s_wdata, exp_owner ? 32'h200 : 32'h100);
            @(negedge clock); #1;
            check("t2_gap_busy", 32'(busy), 0);
            check("t2_gap_gnt1", 32'(m1_gnt), 0);
            $display("txn2.%0d contention grant to m%0d", k, exp_owner);
        end

        // Read burst wrapping the address space; a late wr on the owner is ignored.
        m1_rd = 1; m1_address = 4'hE; m1_length = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            s_rdata = 32'h11 + 32'(i);
            if (i == 1) m1_wr = 1;
            if (i == 3) begin m1_rd = 0; m1_wr = 0; end
            #1;
            check("t3_saddr", 32'(s_address), 32'((4'hE + 4'(i)) & 4'hF));
            check("t3_rdat1", m1_rdata, 32'h11 + 32'(i));
            check("t3_rdat0", m0_rdata, 0);
            check("t3_srd", 32'(s_rd), 1);
            check("t3_swr", 32'(s_wr), 0);
            check("t3_rdy1", 32'(m1_ready), 1);
            check("t3_rdy0", 32'(m0_ready), 0);
        end
        @(negedge clock); #1;
        check("t3_idle_busy", 32'(busy), 0);
        check("t3_idle_rdat1", m1_rdata, 0);
        $display("txn3 m1 read addr=0xE len=3 done");

        // Both wr and rd high: the burst is a write.
        m0_wr = 1; m0_rd = 1; m0_address = 4'h0; m0_length = 4'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (i == 2) begin m0_wr = 0; m0_rd = 0; end
            #1;
            check("t4_swr", 32'(s_wr), 1);
            check("t4_srd", 32'(s_rd), 0);
            check("t4_saddr", 32'(s_address), 32'(i));
        end
        @(negedge clock); #1;
        check("t4_idle_busy", 32'(busy), 0);
        $display("txn4 m0 wr+rd addr=0x0 len=2 done");

        // Reset during the 2nd of 4 beats, then re-grant at a new address.
        m0_wr = 1; m0_address = 4'h3; m0_length = 4'd3; m0_wdata = 32'h55; s_rdata = 32'h99;
        @(negedge clock); #1;
        check("t5_saddr_b0", 32'(s_address), 32'h3);
        @(negedge clock); #1;
        check("t5_saddr_b1", 32'(s_address), 32'h4);
        reset = 1'b0; m0_address = 4'h9;
        #1 check_all_zero("t5_rst");
        @(negedge clock); reset = 1'b1;
        #1 check("t5_rel_busy", 32'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 3) m0_wr = 0;
            #1;
            check("t5_busy", 32'(busy), 1);
            check("t5_saddr", 32'(s_address), 32'h9 + 32'(i));
            check("t5_slen", 32'(s_length), 3);
        end
        @(negedge clock); #1;
        check("t5_idle_busy", 32'(busy), 0);
        $display("txn5 m0 write after reset addr=0x9 len=3 done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
